// File: rtl/scan_frame_ctrl.sv
// Scanner revolution-lock tracker, config shadowing and frame handshake.
// Optional revolution watchdog enabled by defining SCAN_FRAME_CTRL_TIMEOUT_EN.
module scan_frame_ctrl #(
    parameter int unsigned PTS_PER_REV = 1081,
    parameter int unsigned STABLE_REVS = 3,
    parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        zero_flag,
    input  logic        point_valid,
    input  logic        cfg_wr,
    input  logic [15:0] cfg_angle_offset,
    input  logic [7:0]  cfg_min_dist,
    input  logic        cycle_enable,
    output logic [15:0] angle_offset,
    output logic [7:0]  min_display_distance,
    output logic        frame_req,
    input  logic        frame_ack,
    output logic [15:0] frame_id,
    output logic        stable,
    output logic [1:0]  err_code
);

    localparam int unsigned PCNT_W = 12;
    localparam int unsigned GCNT_W = (STABLE_REVS < 2) ? 1 : $clog2(STABLE_REVS + 1);
    localparam int unsigned ID_W   = 16;
    localparam int unsigned OFF_W  = 16;
    localparam int unsigned DIST_W = 8;
    localparam int unsigned ERR_W  = 2;

    localparam logic [PCNT_W-1:0] PCNT_MAX    = '1;
    localparam logic [ERR_W-1:0]  ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0]  ERR_BADREV  = 2'd1;
    localparam logic [ERR_W-1:0]  ERR_TIMEOUT = 2'd2;
    localparam logic [ERR_W-1:0]  ERR_OVERRUN = 2'd3;

    // Elaboration-time parameter sanity
    if (PTS_PER_REV == 0 || PTS_PER_REV > 4094) begin : g_bad_pts
        $error("PTS_PER_REV out of range for 12-bit point counter");
    end
    if (STABLE_REVS == 0) begin : g_bad_revs
        $error("STABLE_REVS must be at least 1");
    end
    if (TIMEOUT_CYC == 24'd0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be nonzero");
    end

    typedef enum logic [3:0] {
        S_INIT    = 4'b0001,
        S_MEASURE = 4'b0010,
        S_RUN     = 4'b0100,
        S_FAULT   = 4'b1000
    } state_e;

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   pt_cnt_q, pt_cnt_d;
    logic [GCNT_W-1:0]   good_q, good_d, good_inc_c;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                frame_req_q, frame_req_d;
    logic [ID_W-1:0]     frame_id_q, frame_id_d;
    logic                stable_q;
    logic                cyc_en_q;
    logic [OFF_W-1:0]    shadow_off_q, angle_off_q;
    logic [DIST_W-1:0]   shadow_dist_q, dist_q;
    logic                rev_good_c, fall_c, wdog_hit_c;

`ifdef SCAN_FRAME_CTRL_TIMEOUT_EN
    logic [23:0] wdog_q;

    // Cycles since the last revolution index; saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (zero_flag || state_q == S_INIT) begin
            wdog_q <= '0;
        end else if (wdog_q != '1) begin
            wdog_q <= wdog_q + 24'd1;
        end
    end

    assign wdog_hit_c = (wdog_q >= TIMEOUT_CYC);
`else
    assign wdog_hit_c = 1'b0;
`endif

    assign rev_good_c = (pt_cnt_q == PCNT_W'(PTS_PER_REV));
    assign fall_c     = cyc_en_q && !cycle_enable;
    assign good_inc_c = good_q + GCNT_W'(1);

    always_comb begin
        state_d     = state_q;
        pt_cnt_d    = pt_cnt_q;
        good_d      = good_q;
        err_d       = err_q;
        frame_req_d = frame_req_q;
        frame_id_d  = frame_id_q;

        // A point coincident with the index is the first point of the new revolution
        if (zero_flag) begin
            pt_cnt_d = PCNT_W'(point_valid);
        end else if (point_valid && pt_cnt_q != PCNT_MAX) begin
            pt_cnt_d = pt_cnt_q + PCNT_W'(1);
        end

        unique case (state_q)
            S_INIT: begin
                if (zero_flag) begin
                    state_d = S_MEASURE;
                    good_d  = '0;
                end
            end
            S_MEASURE: begin
                if (wdog_hit_c) begin
                    state_d = S_FAULT;
                    err_d   = ERR_TIMEOUT;
                end else if (zero_flag) begin
                    if (rev_good_c) begin
                        good_d = good_inc_c;
                        if (good_inc_c == GCNT_W'(STABLE_REVS)) begin
                            state_d = S_RUN;
                        end
                    end else begin
                        good_d = '0;
                        err_d  = ERR_BADREV;
                    end
                end
            end
            S_RUN: begin
                if (wdog_hit_c) begin
                    state_d = S_FAULT;
                    err_d   = ERR_TIMEOUT;
                end else if (zero_flag) begin
                    if (rev_good_c) begin
                        err_d = ERR_NONE;
                    end else begin
                        state_d = S_MEASURE;
                        good_d  = '0;
                        err_d   = ERR_BADREV;
                    end
                end
            end
            S_FAULT: begin
                if (zero_flag) begin
                    state_d = S_INIT;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = S_INIT;
                good_d  = '0;
            end
        endcase

        if (frame_req_q && frame_ack) begin
            frame_req_d = 1'b0;
        end

        // Frames complete only while remaining in RUN; an unacked request drops the new frame
        if (state_q == S_RUN && state_d == S_RUN && fall_c) begin
            if (frame_req_q && !frame_ack) begin
                err_d = ERR_OVERRUN;
            end else begin
                frame_id_d  = frame_id_q + ID_W'(1);
                frame_req_d = 1'b1;
            end
        end

        if (state_d != S_RUN) begin
            frame_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            pt_cnt_q    <= '0;
            good_q      <= '0;
            err_q       <= ERR_NONE;
            frame_req_q <= 1'b0;
            frame_id_q  <= '0;
            stable_q    <= 1'b0;
            cyc_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pt_cnt_q    <= pt_cnt_d;
            good_q      <= good_d;
            err_q       <= err_d;
            frame_req_q <= frame_req_d;
            frame_id_q  <= frame_id_d;
            stable_q    <= (state_d == S_RUN);
            cyc_en_q    <= cycle_enable;
        end
    end

    // Host config is shadowed and applied only at a revolution boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_off_q  <= '0;
            shadow_dist_q <= '0;
            angle_off_q   <= '0;
            dist_q        <= '0;
        end else begin
            if (zero_flag) begin
                angle_off_q <= shadow_off_q;
                dist_q      <= shadow_dist_q;
            end
            if (cfg_wr) begin
                shadow_off_q  <= cfg_angle_offset;
                shadow_dist_q <= cfg_min_dist;
            end
        end
    end

    assign angle_offset         = angle_off_q;
    assign min_display_distance = dist_q;
    assign frame_req            = frame_req_q;
    assign frame_id             = frame_id_q;
    assign stable               = stable_q;
    assign err_code             = err_q;

endmodule
